// File: rtl/fx3_pll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fx3_pll_ctrl_pkg
// Brief   : Shared state encoding and width helper for the FX3 PLL supervisor.
// Revision: 1.0 - initial release
// ============================================================================
package fx3_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    QUALIFY   = 3'd2,
    LOCKED    = 3'd3,
    FAULT     = 3'd4
  } pll_state_t;

  // Ceiling log2; callers pass (max_value + 1) to get a counter width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_sync.sv
`default_nettype none
// ============================================================================
// Module  : pll_lock_sync
// Brief   : Two-flop synchronizer for asynchronous PLL lock indications.
// Revision: 1.0 - initial release
// ============================================================================
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
    end
  end

  assign sync_out = r_sync;

endmodule
`default_nettype wire

// File: rtl/fx3_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fx3_pll_ctrl
// Brief   : FX3 interface PLL reset sequencer, lock qualifier and retry/fault
//           supervisor.
// Revision: 1.0 - initial release
// ============================================================================
module fx3_pll_ctrl
  import fx3_pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       clk_ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  // One counter serves both the reset pulse and the lock-stable window.
  localparam int c_cnt_max = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                             RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int c_cnt_w   = clog2(c_cnt_max + 1);
  localparam int c_to_w    = clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [c_cnt_w-1:0] c_pulse_last  = c_cnt_w'(RST_PULSE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_to_w-1:0]  c_to_last     = c_to_w'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]         c_max_retries = 4'(MAX_RETRIES);

  pll_state_t          r_state, w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
  logic [c_to_w-1:0]   r_to, w_to_nxt;
  logic [3:0]          r_retry, w_retry_nxt;
  logic [7:0]          r_loss, w_loss_nxt;
  logic                r_pll_rst, r_ready, r_fault;
  logic                w_locked_s;
  logic                w_timeout;

  pll_lock_sync u_lock_sync (
    .clk      (clock),
    .rst_n    (reset_n),
    .async_in (pll_locked),
    .sync_out (w_locked_s)
  );

  assign w_timeout = (r_to == c_to_last);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_to_nxt    = r_to;
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;
    if (restart) begin
      w_state_nxt = RESET_PLL;
      w_cnt_nxt   = '0;
      w_to_nxt    = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        RESET_PLL: begin
          if (r_cnt == c_pulse_last) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = '0;
            w_to_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        WAIT_LOCK, QUALIFY: begin
          // Timeout spans QUALIFY bounces and outranks a completing qualification.
          w_to_nxt = r_to + 1'b1;
          if (w_timeout) begin
            w_cnt_nxt = '0;
            if (r_retry == c_max_retries) begin
              w_state_nxt = FAULT;
            end else begin
              w_state_nxt = RESET_PLL;
              w_retry_nxt = r_retry + 1'b1;
            end
          end else if (r_state == WAIT_LOCK) begin
            if (w_locked_s) begin
              w_state_nxt = QUALIFY;
              w_cnt_nxt   = '0;
            end
          end else if (!w_locked_s) begin
            w_state_nxt = WAIT_LOCK;
          end else if (r_cnt == c_stable_last) begin
            w_state_nxt = LOCKED;
            w_retry_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (!w_locked_s) begin
            w_state_nxt = RESET_PLL;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
            if (r_loss != 8'hFF) w_loss_nxt = r_loss + 1'b1;
          end
        end
        FAULT: begin
          w_state_nxt = FAULT;
        end
        default: begin
          w_state_nxt = RESET_PLL;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= RESET_PLL;
      r_cnt     <= '0;
      r_to      <= '0;
      r_retry   <= '0;
      r_loss    <= '0;
      r_pll_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_to      <= w_to_nxt;
      r_retry   <= w_retry_nxt;
      r_loss    <= w_loss_nxt;
      // Flags track the state being entered so they change on the same edge.
      r_pll_rst <= (w_state_nxt == RESET_PLL) || (w_state_nxt == FAULT);
      r_ready   <= (w_state_nxt == LOCKED);
      r_fault   <= (w_state_nxt == FAULT);
    end
  end

  assign pll_rst         = r_pll_rst;
  assign clk_ready       = r_ready;
  assign fault           = r_fault;
  assign retry_count     = r_retry;
  assign lock_loss_count = r_loss;

endmodule
`default_nettype wire

// File: tb/tb_fx3_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fx3_pll_ctrl
// Brief   : Directed self-checking bench for fx3_pll_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fx3_pll_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       clk_ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  fx3_pll_ctrl #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .restart         (restart),
    .pll_rst         (pll_rst),
    .clk_ready       (clk_ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Cycles spent while pll_rst stays at lvl (bounded at 200).
  task automatic cnt_rst(input logic lvl, output int n);
    n = 0;
    while (pll_rst === lvl && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  task automatic cnt_ready(input logic lvl, output int n);
    n = 0;
    while (clk_ready === lvl && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    int   to_cnt;
    int   hit;
    logic seen;

    reset_n    = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;
    tick(3);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_ready", clk_ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retry", retry_count, 0);
    chk("rst_loss", lock_loss_count, 0);

    // Power-up acquisition: lock arrives 10 cycles after pll_rst falls
    reset_n = 1'b1;
    cnt_rst(1'b1, n);   chk("t1_pulse_len", n, 4);
    tick(10);
    pll_locked = 1'b1;
    cnt_ready(1'b0, n); chk("t1_ready_latency", n, 11);
    chk("t1_pll_rst", pll_rst, 0);
    chk("t1_retry", retry_count, 0);
    chk("t1_fault", fault, 0);

    // Lock loss in LOCKED for 3 cycles
    pll_locked = 1'b0;
    cnt_ready(1'b1, n); chk("t3_drop_latency", n, 3);
    chk("t3_loss", lock_loss_count, 1);
    chk("t3_pll_rst", pll_rst, 1);
    pll_locked = 1'b1;
    cnt_rst(1'b1, n);   chk("t3_pulse_len", n, 4);
    cnt_ready(1'b0, n); chk("t3_requal", n, 9);

    // Lock toggling every 5 cycles while qualifying
    pll_locked = 1'b0;
    restart    = 1'b1;
    tick(1);
    restart    = 1'b0;
    chk("t4_restart_ready", clk_ready, 0);
    chk("t4_restart_rst", pll_rst, 1);
    chk("t4_loss_kept", lock_loss_count, 1);
    cnt_rst(1'b1, n);   chk("t4_pulse_len", n, 4);
    seen = 1'b0;
    hit  = 0;
    for (int i = 1; i <= 40; i++) begin
      if ((i - 1) % 5 == 0) pll_locked = ~pll_locked;
      tick(1);
      if (clk_ready) seen = 1'b1;
      if (hit == 0 && retry_count == 4'd1) hit = i;
    end
    chk("t4_never_ready", seen, 0);
    chk("t4_timeout_at", hit, 32);
    chk("t4_retry", retry_count, 1);

    // No lock at all: three attempts then FAULT
    pll_locked = 1'b0;
    restart    = 1'b1;
    tick(1);
    restart    = 1'b0;
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("t2_retry_%0d", p), retry_count, p);
      cnt_rst(1'b1, n); chk($sformatf("t2_pulse_%0d", p), n, 4);
      cnt_rst(1'b0, n); chk($sformatf("t2_wait_%0d", p), n, 32);
    end
    chk("t2_fault", fault, 1);
    chk("t2_fault_retry", retry_count, 2);
    chk("t2_fault_ready", clk_ready, 0);
    tick(50);
    chk("t2_fault_hold", fault, 1);
    chk("t2_fault_rst_hold", pll_rst, 1);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("t2_restart_fault", fault, 0);
    chk("t2_restart_rst", pll_rst, 1);
    chk("t2_restart_retry", retry_count, 0);
    cnt_rst(1'b1, n);   chk("t2_new_pulse", n, 4);

    // 300 lock losses: counter saturates
    pll_locked = 1'b1;
    cnt_ready(1'b0, n);
    chk("t5_first_lock", clk_ready, 1);
    to_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      pll_locked = 1'b0;
      cnt_ready(1'b1, n);
      if (n >= 200) to_cnt++;
      pll_locked = 1'b1;
      cnt_ready(1'b0, n);
      if (n >= 200) to_cnt++;
      if (k == 9) chk("t5_loss_11", lock_loss_count, 11);
    end
    chk("t5_timeouts", to_cnt, 0);
    chk("t5_saturated", lock_loss_count, 255);

    // Asynchronous reset in the middle of QUALIFY
    pll_locked = 1'b0;
    cnt_ready(1'b1, n);
    pll_locked = 1'b1;
    cnt_rst(1'b1, n);
    tick(3);
    chk("t6_loss_hold", lock_loss_count, 255);
    chk("t6_qualify_rst", pll_rst, 0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_async_rst", pll_rst, 1);
    chk("t6_async_ready", clk_ready, 0);
    chk("t6_async_fault", fault, 0);
    chk("t6_async_retry", retry_count, 0);
    chk("t6_async_loss", lock_loss_count, 0);
    reset_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
